// File: rtl/sample_loader_pkg.sv
// Shared definitions for the sample loader and the correlator that reads its stores.
//   - loader_state_e : entry FSM state encodings (WAIT_A, WAIT_B, FULL)
//   - DATA_W_DEF     : default sample width, equal to the A/B ROM word width
//   - DEPTH_DEF      : default entries per store, equal to the A/B ROM depth
package sample_loader_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 9;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        FULL   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/sample_loader_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and
// rising-edge detector on the debounced level.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous reset, active-high
//   btn    in  1  raw asynchronous, bouncy button
//   accept out 1  one-cycle pulse when the debounced level goes 0->1
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 15000000,
    parameter int DEBOUNCE_W   = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic accept
);

    logic                  sync_meta_r;
    logic                  sync_r;
    logic                  level_r;
    logic [DEBOUNCE_W-1:0] cnt_r;
    logic                  accept_r;

    // Synchronize the button, count how long it disagrees with the accepted level, flip on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
            level_r     <= 1'b0;
            cnt_r       <= {DEBOUNCE_W{1'b0}};
            accept_r    <= 1'b0;
        end else begin
            sync_meta_r <= btn;
            sync_r      <= sync_meta_r;
            accept_r    <= 1'b0;
            if (sync_r != level_r) begin
                if (cnt_r == DEBOUNCE_W'(DEBOUNCE_CNT - 1)) begin
                    level_r  <= sync_r;
                    cnt_r    <= {DEBOUNCE_W{1'b0}};
                    // Only a press (new level high) produces an accept; a release is silent.
                    accept_r <= sync_r;
                end else begin
                    cnt_r <= cnt_r + DEBOUNCE_W'(1);
                end
            end else begin
                // Any return to agreement restarts the stability window.
                cnt_r <= {DEBOUNCE_W{1'b0}};
            end
        end
    end

    assign accept = accept_r;

endmodule

// File: rtl/sample_loader.sv
// Write side of the correlator's sample stores. Each debounced button press
// captures data_sw, alternating store A then store B at the same pointer.
// Ports:
//   clk       in   1       system clock
//   reset     in   1       synchronous reset, active-high; clears both stores
//   data_sw   in   DATA_W  sample value, captured on an accepted press
//   load_btn  in   1       raw pushbutton
//   rd_addr   in   ADDR_W  correlator read address
//   rd_a      out  DATA_W  store A at rd_addr (combinational, 0 if out of range)
//   rd_b      out  DATA_W  store B at rd_addr (combinational, 0 if out of range)
//   wr_count  out  ADDR_W  number of complete A/B pairs written
//   expect_b  out  1       next press writes store B
//   full      out  1       all DEPTH pairs written
//   wr_pulse  out  1       one-cycle strobe the cycle after a store write
module sample_loader
    import sample_loader_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int ADDR_W       = 4,
    parameter int DEBOUNCE_CNT = 15000000,
    parameter int DEBOUNCE_W   = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_sw,
    input  logic              load_btn,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [ADDR_W-1:0] wr_count,
    output logic              expect_b,
    output logic              full,
    output logic              wr_pulse
);

    logic              accept_s;
    loader_state_e     state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              expect_b_r;
    logic              full_r;
    logic              wr_pulse_r;
    logic [DATA_W-1:0] mem_a_r [DEPTH];
    logic [DATA_W-1:0] mem_b_r [DEPTH];
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    btn_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .DEBOUNCE_W   (DEBOUNCE_W)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn    (load_btn),
        .accept (accept_s)
    );

    // Entry FSM, store writes and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= WAIT_A;
            ptr_r      <= {ADDR_W{1'b0}};
            expect_b_r <= 1'b0;
            full_r     <= 1'b0;
            wr_pulse_r <= 1'b0;
            // Clearing the whole store also discards a half-entered pair.
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i] <= {DATA_W{1'b0}};
                mem_b_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wr_pulse_r <= accept_s && (state_r != FULL);
            case (state_r)
                WAIT_A: begin
                    if (accept_s) begin
                        mem_a_r[ptr_r] <= data_sw;
                        state_r        <= WAIT_B;
                        expect_b_r     <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (accept_s) begin
                        mem_b_r[ptr_r] <= data_sw;
                        ptr_r          <= ptr_r + ADDR_W'(1);
                        expect_b_r     <= 1'b0;
                        if (ptr_r == ADDR_W'(DEPTH - 1)) begin
                            state_r <= FULL;
                            full_r  <= 1'b1;
                        end else begin
                            state_r <= WAIT_A;
                        end
                    end
                end
                FULL: begin
                    // Terminal until reset: presses are ignored and the pointer never wraps.
                    state_r <= FULL;
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle state without writing.
                    state_r    <= WAIT_A;
                    expect_b_r <= 1'b0;
                    full_r     <= 1'b0;
                end
            endcase
        end
    end

    // Asynchronous read port; addresses beyond the store read as zero.
    always_comb begin
        rd_a_s = {DATA_W{1'b0}};
        rd_b_s = {DATA_W{1'b0}};
        if (32'(rd_addr) < DEPTH) begin
            rd_a_s = mem_a_r[rd_addr];
            rd_b_s = mem_b_r[rd_addr];
        end else begin
            rd_a_s = {DATA_W{1'b0}};
            rd_b_s = {DATA_W{1'b0}};
        end
    end

    assign rd_a     = rd_a_s;
    assign rd_b     = rd_b_s;
    assign wr_count = ptr_r;
    assign expect_b = expect_b_r;
    assign full     = full_r;
    assign wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_sample_loader.sv
module tb_sample_loader;

    localparam int DW  = 4;
    localparam int DEP = 9;
    localparam int AW  = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_sw;
    logic          load_btn;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic [AW-1:0] wr_count;
    logic          expect_b;
    logic          full;
    logic          wr_pulse;

    sample_loader #(
        .DATA_W       (DW),
        .DEPTH        (DEP),
        .ADDR_W       (AW),
        .DEBOUNCE_CNT (4),
        .DEBOUNCE_W   (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_sw  (data_sw),
        .load_btn (load_btn),
        .rd_addr  (rd_addr),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .wr_count (wr_count),
        .expect_b (expect_b),
        .full     (full),
        .wr_pulse (wr_pulse)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: two sample arrays plus entry progress.
    logic [DW-1:0] m_a [DEP];
    logic [DW-1:0] m_b [DEP];
    int            m_pairs;
    bit            m_expb;
    bit            m_full;

    // Per-press observations.
    int            pulses;
    bit            seen;
    logic [DW-1:0] prev_rd;
    logic [DW-1:0] rd_before;
    logic [DW-1:0] rd_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_a[i] = 4'd0;
            m_b[i] = 4'd0;
        end
        m_pairs = 0;
        m_expb  = 1'b0;
        m_full  = 1'b0;
    endtask

    // Returns 1 when this press should write a store.
    function automatic bit model_press(input logic [DW-1:0] d);
        if (m_full) return 1'b0;
        if (!m_expb) begin
            m_a[m_pairs] = d;
            m_expb = 1'b1;
        end else begin
            m_b[m_pairs] = d;
            m_pairs++;
            m_expb = 1'b0;
            m_full = (m_pairs == DEP);
        end
        return 1'b1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(m_pairs));
        chk({tag, ".expect_b"}, 32'(expect_b), 32'(m_expb));
        chk({tag, ".full"},     32'(full),     32'(m_full));
        chk({tag, ".wr_pulse"}, 32'(wr_pulse), 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd_addr = AW'(a);
            #1;
            chk($sformatf("%s.rd_a[%0d]", tag, a), 32'(rd_a), (a < DEP) ? 32'(m_a[a]) : 32'd0);
            chk($sformatf("%s.rd_b[%0d]", tag, a), 32'(rd_b), (a < DEP) ? 32'(m_b[a]) : 32'd0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (wr_pulse) begin
            pulses++;
            if (!seen) begin
                seen      = 1'b1;
                rd_before = prev_rd;
                rd_after  = rd_a;
            end
        end
        prev_rd = rd_a;
    endtask

    // One operator entry: optional bounce, hold high, then a stable release.
    task automatic press(input logic [DW-1:0] d, input int hold, input bit bouncy);
        pulses  = 0;
        seen    = 1'b0;
        prev_rd = rd_a;
        data_sw = d;
        if (bouncy) begin
            for (int i = 0; i < 12; i++) begin
                load_btn = ((i / 2) % 2) == 0;
                step();
            end
        end
        load_btn = 1'b1;
        for (int i = 0; i < hold; i++) step();
        load_btn = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic press_and_check(input string tag, input logic [DW-1:0] d,
                                   input int hold, input bit bouncy);
        bit w;
        press(d, hold, bouncy);
        w = model_press(d);
        chk({tag, ".pulses"}, 32'(pulses), w ? 32'd1 : 32'd0);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        load_btn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [DW-1:0] d;
        reset    = 1'b1;
        load_btn = 1'b0;
        data_sw  = 4'd0;
        rd_addr  = 4'd0;

        // Reset state.
        do_reset();
        check_all("reset");

        // First pair, plus read-during-write on address 0.
        rd_addr = 4'd0;
        press(4'd3, 10, 1'b0);
        void'(model_press(4'd3));
        chk("a0.pulses",    32'(pulses),    32'd1);
        chk("a0.rd_before", 32'(rd_before), 32'd0);
        chk("a0.rd_after",  32'(rd_after),  32'd3);
        check_all("a0");
        press_and_check("b0", 4'd5, 10, 1'b0);

        // Bouncy press and a long hold each give one write.
        press_and_check("bouncy", DW'($urandom_range(0, 15)), 20, 1'b1);
        press_and_check("hold100", DW'($urandom_range(0, 15)), 100, 1'b0);

        // Random values and hold lengths.
        for (int k = 0; k < 4; k++) begin
            press_and_check($sformatf("rnd%0d", k), DW'($urandom_range(0, 15)),
                            int'($urandom_range(8, 30)), 1'b0);
        end

        // Fill all nine pairs from a clean start.
        do_reset();
        check_all("reset2");
        for (int k = 1; k <= 18; k++) begin
            press_and_check($sformatf("fill%0d", k), DW'(k % 16), 10, 1'b0);
        end
        chk("fill.full",     32'(full),     32'd1);
        chk("fill.wr_count", 32'(wr_count), 32'd9);
        rd_addr = 4'd8;
        #1;
        chk("fill.mem_a8", 32'(rd_a), 32'd1);
        chk("fill.mem_b8", 32'(rd_b), 32'd2);
        press_and_check("press19", DW'($urandom_range(0, 15)), 10, 1'b0);

        // Reset while a pair is half entered.
        do_reset();
        d = DW'($urandom_range(1, 15));
        press_and_check("half", d, 10, 1'b0);
        chk("half.expect_b", 32'(expect_b), 32'd1);
        do_reset();
        check_all("midreset");

        // Out-of-range read after data is present.
        press_and_check("oor.a", 4'd9, 10, 1'b0);
        rd_addr = 4'd12;
        #1;
        chk("oor.rd_a", 32'(rd_a), 32'd0);
        chk("oor.rd_b", 32'(rd_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
